// File: rtl/multi_count_toggle.sv
// Multi-channel count-and-toggle: each channel divides the clock by a runtime
// limit, producing a square wave and a terminal-count strobe; one is muxed out.
module multi_count_toggle #(
    parameter int NUM_CH        = 4,
    parameter int CNT_W         = 24,
    parameter int DEFAULT_LIMIT = 10,
    localparam int SEL_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              i_Clk,
    input  logic              i_Reset,
    input  logic [NUM_CH-1:0] i_Enable,
    input  logic              i_Wr_En,
    input  logic [SEL_W-1:0]  i_Wr_Addr,
    input  logic [CNT_W-1:0]  i_Wr_Data,
    input  logic [SEL_W-1:0]  i_Sel,
    output logic [NUM_CH-1:0] o_Toggle,
    output logic [NUM_CH-1:0] o_Pulse,
    output logic              o_Sel_Toggle
);

    logic [CNT_W-1:0]         limit_q  [NUM_CH];
    logic [CNT_W-1:0]         count_q  [NUM_CH];
    logic [CNT_W-1:0]         term_cnt [NUM_CH];
    logic [NUM_CH-1:0]        wr_hit;
    logic [(1<<SEL_W)-1:0]    toggle_pad;

    // Zero-padding the toggle vector makes out-of-range selects read 0.
    always_comb begin
        toggle_pad                = '0;
        toggle_pad[NUM_CH-1:0]    = o_Toggle;
        wr_hit                    = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            wr_hit[c]   = i_Wr_En && (i_Wr_Addr == SEL_W'(c));
            term_cnt[c] = (limit_q[c] == '0) ? '0 : limit_q[c] - 1'b1;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                count_q[c] <= '0;
                limit_q[c] <= CNT_W'(DEFAULT_LIMIT);
            end
            o_Toggle     <= '0;
            o_Pulse      <= '0;
            o_Sel_Toggle <= 1'b0;
        end else begin
            o_Sel_Toggle <= toggle_pad[i_Sel];
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                if (wr_hit[c])
                    limit_q[c] <= i_Wr_Data;
                // Disable beats write, write beats terminal count.
                if (!i_Enable[c]) begin
                    count_q[c]  <= '0;
                    o_Toggle[c] <= 1'b0;
                    o_Pulse[c]  <= 1'b0;
                end else if (wr_hit[c]) begin
                    count_q[c]  <= '0;
                    o_Pulse[c]  <= 1'b0;
                end else if (count_q[c] == term_cnt[c]) begin
                    count_q[c]  <= '0;
                    o_Toggle[c] <= ~o_Toggle[c];
                    o_Pulse[c]  <= 1'b1;
                end else begin
                    count_q[c]  <= count_q[c] + 1'b1;
                    o_Pulse[c]  <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_multi_count_toggle.sv
// Self-checking bench: a cycle model feeds a scoreboard for the 4-channel DUT,
// plus directed checks on a 3-channel instance for out-of-range addressing.
module tb_multi_count_toggle;

    logic        clk = 1'b0;
    logic        rst, wr_en, sel_o;
    logic [3:0]  en, tog, pls;
    logic [1:0]  wr_addr, sel;
    logic [23:0] wr_data;

    logic        b_rst, b_wr_en, b_sel_o;
    logic [2:0]  b_en, b_tog, b_pls;
    logic [1:0]  b_wr_addr, b_sel;
    logic [23:0] b_wr_data;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct { logic [3:0] tog; logic [3:0] pls; logic sel; } exp_t;
    exp_t sb[$];

    int         m_cnt [4];
    int         m_lim [4];
    logic [3:0] m_tog, m_pls;
    logic       m_sel;

    always #5 clk = ~clk;

    multi_count_toggle #(.NUM_CH(4), .CNT_W(24), .DEFAULT_LIMIT(10)) dut (
        .i_Clk(clk), .i_Reset(rst), .i_Enable(en), .i_Wr_En(wr_en),
        .i_Wr_Addr(wr_addr), .i_Wr_Data(wr_data), .i_Sel(sel),
        .o_Toggle(tog), .o_Pulse(pls), .o_Sel_Toggle(sel_o)
    );

    multi_count_toggle #(.NUM_CH(3), .CNT_W(24), .DEFAULT_LIMIT(2)) dut_b (
        .i_Clk(clk), .i_Reset(b_rst), .i_Enable(b_en), .i_Wr_En(b_wr_en),
        .i_Wr_Addr(b_wr_addr), .i_Wr_Data(b_wr_data), .i_Sel(b_sel),
        .o_Toggle(b_tog), .o_Pulse(b_pls), .o_Sel_Toggle(b_sel_o)
    );

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Advance the model one edge, push its prediction, clock the DUT, compare.
    task automatic tick();
        exp_t       e;
        logic [3:0] tog_old;
        int         eff;
        logic       hit;
        tog_old = m_tog;
        if (rst) begin
            for (int c = 0; c < 4; c++) begin m_cnt[c] = 0; m_lim[c] = 10; end
            m_tog = '0; m_pls = '0; m_sel = 1'b0;
        end else begin
            m_sel = tog_old[sel];
            for (int c = 0; c < 4; c++) begin
                hit = wr_en && (int'(wr_addr) == c);
                eff = (m_lim[c] == 0) ? 1 : m_lim[c];
                if (!en[c]) begin
                    m_cnt[c] = 0; m_tog[c] = 1'b0; m_pls[c] = 1'b0;
                end else if (hit) begin
                    m_cnt[c] = 0; m_pls[c] = 1'b0;
                end else if (m_cnt[c] + 1 == eff) begin
                    m_cnt[c] = 0; m_tog[c] = ~m_tog[c]; m_pls[c] = 1'b1;
                end else begin
                    m_cnt[c]++; m_pls[c] = 1'b0;
                end
                if (hit) m_lim[c] = int'(wr_data);
            end
        end
        e.tog = m_tog; e.pls = m_pls; e.sel = m_sel;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("sb_toggle", 32'(tog),   32'(e.tog));
        chk("sb_pulse",  32'(pls),   32'(e.pls));
        chk("sb_sel",    32'(sel_o), 32'(e.sel));
    endtask

    task automatic ticks(int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        rst = 1'b1; en = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; sel = '0;
        b_rst = 1'b1; b_en = '0; b_wr_en = 1'b0; b_wr_addr = '0; b_wr_data = '0; b_sel = '0;
        for (int c = 0; c < 4; c++) begin m_cnt[c] = 0; m_lim[c] = 0; end
        m_tog = '0; m_pls = '0; m_sel = 1'b0;
        #2;
        ticks(2);
        chk("reset_toggle", 32'(tog), 0);
        chk("reset_pulse",  32'(pls), 0);
        rst = 1'b0;

        // Channel 0 alone at the default limit
        en = 4'b0001;
        ticks(9);
        chk("ch0_before_first_rise", 32'(tog[0]), 0);
        tick();
        chk("ch0_first_rise", 32'(tog[0]), 1);
        chk("ch0_first_pulse", 32'(pls[0]), 1);
        ticks(30);

        // Two more channels at limits 3 and 5
        wr_en = 1'b1; wr_addr = 2'd1; wr_data = 24'd3; tick();
        wr_addr = 2'd2; wr_data = 24'd5; tick();
        wr_en = 1'b0; en = 4'b0111;
        ticks(15);
        chk("coincident_pulse_ch1", 32'(pls[1]), 1);
        chk("coincident_pulse_ch2", 32'(pls[2]), 1);
        ticks(10);

        // Mid-count limit rewrite on channel 0
        en[0] = 1'b0; tick();
        en[0] = 1'b1; ticks(7);
        wr_en = 1'b1; wr_addr = 2'd0; wr_data = 24'd4; tick();
        chk("write_edge_no_pulse", 32'(pls[0]), 0);
        chk("write_edge_toggle_held", 32'(tog[0]), 0);
        wr_en = 1'b0;
        ticks(3);
        chk("new_limit_not_yet", 32'(tog[0]), 0);
        tick();
        chk("new_limit_toggle", 32'(tog[0]), 1);
        chk("new_limit_pulse", 32'(pls[0]), 1);

        // Limit 0 behaves as 1
        wr_en = 1'b1; wr_data = 24'd0; tick();
        wr_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("limit0_pulse_high", 32'(pls[0]), 1);
        end

        // Disable for 5 cycles, then re-enable
        en[0] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("disabled_toggle", 32'(tog[0]), 0);
            chk("disabled_pulse", 32'(pls[0]), 0);
        end
        en[0] = 1'b1; tick();
        chk("reenable_first_toggle", 32'(tog[0]), 1);

        // Selector sweep with all channels running
        en = 4'b1111;
        wr_en = 1'b1; wr_addr = 2'd3; wr_data = 24'd2; tick();
        wr_en = 1'b0;
        for (int s = 0; s < 4; s++) begin
            sel = 2'(s);
            ticks(6);
        end

        // Reset coinciding with a write: the write is lost
        rst = 1'b1; wr_en = 1'b1; wr_addr = 2'd0; wr_data = 24'd3; tick();
        rst = 1'b0; wr_en = 1'b0;
        chk("reset_mid_toggle", 32'(tog), 0);
        chk("reset_mid_pulse", 32'(pls), 0);
        chk("reset_mid_sel", 32'(sel_o), 0);
        ticks(9);
        chk("post_reset_limit10_early", 32'(tog[0]), 0);
        tick();
        chk("post_reset_limit10_rise", 32'(tog[0]), 1);

        // 3-channel instance: out-of-range select and write address
        b_rst = 1'b0; b_en = 3'b111; b_wr_en = 1'b1; b_wr_addr = 2'd3;
        b_wr_data = 24'd1; b_sel = 2'd3;
        tick();
        chk("b_edge1_toggle", 32'(b_tog), 0);
        chk("b_edge1_sel_oob", 32'(b_sel_o), 0);
        tick();
        chk("b_edge2_toggle", 32'(b_tog), 32'h7);
        chk("b_edge2_sel_oob", 32'(b_sel_o), 0);
        b_sel = 2'd2;
        tick();
        chk("b_edge3_toggle", 32'(b_tog), 32'h7);
        chk("b_edge3_sel_lag", 32'(b_sel_o), 1);
        tick();
        chk("b_edge4_toggle", 32'(b_tog), 0);
        chk("b_edge4_pulse", 32'(b_pls), 32'h7);
        chk("b_edge4_sel_lag", 32'(b_sel_o), 1);
        tick();
        chk("b_edge5_sel_lag", 32'(b_sel_o), 0);
        b_wr_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
